// File: rtl/fetch_if.sv
// ============================================================================
// Module      : fetch_if
// Description : Bundles the program-memory req/ack bus, the decoder
//               valid/ready bus and the branch/halt controls of the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_if #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8
);
    // Program memory side
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;

    // Decoder side
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;

    // Control flow
    logic               branch_valid;
    logic [ADDR_W-1:0]  branch_target;
    logic               halt;
    logic [ADDR_W-1:0]  pc;

    // Fetch unit view
    modport master (
        output mem_req, mem_addr, instr, instr_valid, pc,
        input  mem_ack, mem_rdata, instr_ready, branch_valid, branch_target, halt
    );

    // Environment view (memory, decoder, branch logic)
    modport slave (
        input  mem_req, mem_addr, instr, instr_valid, pc,
        output mem_ack, mem_rdata, instr_ready, branch_valid, branch_target, halt
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch sequencer. Owns the program counter, reads
//               program memory over req/ack and hands each instruction to the
//               decoder over valid/ready. Branches redirect the fetch stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8
) (
    input  wire      clk,
    input  wire      rst,
    fetch_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  pc, pc_next;
    logic               mem_req, mem_req_next;
    logic [INSTR_W-1:0] instr, instr_next;
    logic               instr_valid, instr_valid_next;

    // mem_addr is the registered pc; it is only meaningful while mem_req=1
    assign bus.mem_addr    = pc;
    assign bus.pc          = pc;
    assign bus.mem_req     = mem_req;
    assign bus.instr       = instr;
    assign bus.instr_valid = instr_valid;

    // State and datapath registers; reset wins over every other input
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            mem_req     <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            mem_req     <= mem_req_next;
            instr       <= instr_next;
            instr_valid <= instr_valid_next;
        end
    end

    // Next-state and next-output logic; a branch outranks ack, ready and halt
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        mem_req_next     = mem_req;
        instr_next       = instr;
        instr_valid_next = instr_valid;

        case (state)
            IDLE: begin
                if (bus.branch_valid) begin
                    pc_next = bus.branch_target;
                end
                if (!bus.halt) begin
                    state_next   = REQ;
                    mem_req_next = 1'b1;
                end
            end

            REQ: begin
                if (bus.branch_valid) begin
                    // Any coincident ack is dropped: instr and pc+1 are not taken
                    pc_next          = bus.branch_target;
                    instr_valid_next = 1'b0;
                    if (bus.halt) begin
                        state_next   = IDLE;
                        mem_req_next = 1'b0;
                    end else begin
                        state_next   = REQ;
                        mem_req_next = 1'b1;
                    end
                end else if (bus.mem_ack) begin
                    instr_next       = bus.mem_rdata;
                    instr_valid_next = 1'b1;
                    mem_req_next     = 1'b0;
                    pc_next          = pc + 1'b1;
                    state_next       = HOLD;
                end
            end

            HOLD: begin
                if (bus.branch_valid || bus.instr_ready) begin
                    // A branch discards the held instruction; otherwise it was consumed
                    if (bus.branch_valid) begin
                        pc_next = bus.branch_target;
                    end
                    instr_valid_next = 1'b0;
                    if (bus.halt) begin
                        state_next   = IDLE;
                        mem_req_next = 1'b0;
                    end else begin
                        state_next   = REQ;
                        mem_req_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next       = IDLE;
                mem_req_next     = 1'b0;
                instr_valid_next = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire
